// File: rtl/data_mem_responder.sv
// Purpose: stage-3/4 data memory responder: 256-word RAM, LED, switches, cycle counter, compare/flag MMIO.
// Latency: read data registered, valid exactly one cycle after the address; stores commit at the same edge.
// Backpressure: none; an access is accepted every cycle and a read is always performed (read-first on writes).
module data_mem_responder #(
    parameter int RAM_WORDS   = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [8:0]  addr_mem,
    input  logic [15:0] wdata_mem,
    input  logic        write_mem,
    output logic [15:0] rdata_mem,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out,
    output logic        timer_flag
);

    localparam int AW = $clog2(RAM_WORDS);

    localparam logic [8:0] ADDR_LED  = 9'h100;
    localparam logic [8:0] ADDR_SW   = 9'h140;
    localparam logic [8:0] ADDR_CNT  = 9'h180;
    localparam logic [8:0] ADDR_CMP  = 9'h1C0;
    localparam logic [8:0] ADDR_STAT = 9'h1C1;

    logic [15:0] ram_q [RAM_WORDS];
    logic [15:0] sync_q [SYNC_STAGES];

    logic [15:0] led_q,   led_d;
    logic [15:0] cnt_q,   cnt_d;
    logic [15:0] cmp_q,   cmp_d;
    logic [15:0] rdata_q, rdata_d;
    logic        flag_q,  flag_d;

    logic        is_ram;
    logic        match;
    logic        flag_clr;

    assign is_ram = (int'(addr_mem) < RAM_WORDS);

    // Compare matches use the pre-edge compare value; zero disables the timer.
    assign match = (cnt_q == cmp_q) && (cmp_q != 16'h0000);

    // RAM store port; contents are intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (write_mem && is_ram) begin
            ram_q[addr_mem[AW-1:0]] <= wdata_mem;
        end
    end

    // Register next-state: stores to MMIO, counter clear beats increment, flag set beats clear.
    always_comb begin
        led_d    = led_q;
        cmp_d    = cmp_q;
        cnt_d    = cnt_q + 16'd1;
        flag_clr = 1'b0;
        if (write_mem) begin
            case (addr_mem)
                ADDR_LED:  led_d    = wdata_mem;
                ADDR_CNT:  cnt_d    = 16'h0000;
                ADDR_CMP:  cmp_d    = wdata_mem;
                ADDR_STAT: flag_clr = 1'b1;
                default:   ;
            endcase
        end
        flag_d = match | (flag_q & ~flag_clr);
    end

    // Read mux over pre-edge state, which gives read-first behaviour on every source.
    always_comb begin
        rdata_d = 16'h0000;
        if (is_ram) begin
            rdata_d = ram_q[addr_mem[AW-1:0]];
        end else begin
            case (addr_mem)
                ADDR_LED:  rdata_d = led_q;
                ADDR_SW:   rdata_d = sync_q[SYNC_STAGES-1];
                ADDR_CNT:  rdata_d = cnt_q;
                ADDR_CMP:  rdata_d = cmp_q;
                ADDR_STAT: rdata_d = {15'b0, flag_q};
                default:   rdata_d = 16'h0000;
            endcase
        end
    end

    // State registers and switch synchronizer chain, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q   <= 16'h0000;
            cnt_q   <= 16'h0000;
            cmp_q   <= 16'h0000;
            rdata_q <= 16'h0000;
            flag_q  <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 16'h0000;
            end
        end else begin
            led_q   <= led_d;
            cnt_q   <= cnt_d;
            cmp_q   <= cmp_d;
            rdata_q <= rdata_d;
            flag_q  <= flag_d;
            sync_q[0] <= sw_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rdata_mem  = rdata_q;
    assign led_out    = led_q;
    assign timer_flag = flag_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Purpose: self-checking bench for data_mem_responder against a cycle-indexed behavioural model.
// Latency: each access is checked one edge after it is driven (read data, LED and flag together).
// Backpressure: not applicable; the bench issues one access per cycle.
module tb_data_mem_responder;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  addr_mem;
    logic [15:0] wdata_mem;
    logic        write_mem;
    logic [15:0] rdata_mem;
    logic [15:0] sw_in;
    logic [15:0] led_out;
    logic        timer_flag;

    always #5 clk = ~clk;

    data_mem_responder #(.RAM_WORDS(256), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr_mem   (addr_mem),
        .wdata_mem  (wdata_mem),
        .write_mem  (write_mem),
        .rdata_mem  (rdata_mem),
        .sw_in      (sw_in),
        .led_out    (led_out),
        .timer_flag (timer_flag)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Free-running cycle index; the model derives the counter from it.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model state.
    logic [15:0] m_ram [256];
    logic [15:0] m_led;
    logic [15:0] m_cmp;
    logic        m_flag;
    int          cnt_base;   // cycle index at which the counter reads 0
    logic [15:0] swh [$];    // sw_in values seen on the last SYNC edges
    logic [15:0] last_rd;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %04h expected %04h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] m_cnt();
        return 16'(cyc - cnt_base);
    endfunction

    function automatic logic [15:0] m_read(input logic [8:0] a);
        if (a < 9'h100) return m_ram[a[7:0]];
        case (a)
            9'h100: return m_led;
            9'h140: return (swh.size() == SYNC) ? swh[0] : 16'h0000;
            9'h180: return m_cnt();
            9'h1C0: return m_cmp;
            9'h1C1: return {15'b0, m_flag};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic m_step(input logic [8:0] a, input logic [15:0] d, input logic w);
        logic hit;
        logic clr;
        hit = (m_cnt() == m_cmp) && (m_cmp != 16'h0000);
        clr = 1'b0;
        if (w) begin
            if (a < 9'h100) m_ram[a[7:0]] = d;
            else begin
                case (a)
                    9'h100: m_led = d;
                    9'h180: cnt_base = cyc + 1;
                    9'h1C0: m_cmp = d;
                    9'h1C1: clr = 1'b1;
                    default: ;
                endcase
            end
        end
        m_flag = hit | (m_flag & ~clr);
        swh.push_back(sw_in);
        if (swh.size() > SYNC) void'(swh.pop_front());
    endtask

    // One bus cycle: called at posedge+1, drives, then checks one edge later.
    task automatic access(input logic [8:0] a, input logic [15:0] d, input logic w);
        logic [15:0] exp;
        addr_mem  = a;
        wdata_mem = d;
        write_mem = w;
        exp = m_read(a);
        m_step(a, d, w);
        @(posedge clk);
        #1;
        check_eq($sformatf("rdata@%03h", a), rdata_mem, exp);
        check_eq("led_out", led_out, m_led);
        check_eq("timer_flag", {15'b0, timer_flag}, {15'b0, m_flag});
        last_rd = rdata_mem;
    endtask

    task automatic wr(input logic [8:0] a, input logic [15:0] d);
        access(a, d, 1'b1);
    endtask

    task automatic rd(input logic [8:0] a);
        access(a, $urandom, 1'b0);
    endtask

    task automatic model_reset();
        m_led  = 16'h0000;
        m_cmp  = 16'h0000;
        m_flag = 1'b0;
        swh.delete();
    endtask

    // Mid-cycle asynchronous reset; called at posedge+1.
    task automatic reset_mid();
        write_mem = 1'b0;
        addr_mem  = 9'h1FF;
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst rdata", rdata_mem, 16'h0000);
        check_eq("async_rst led", led_out, 16'h0000);
        check_eq("async_rst flag", {15'b0, timer_flag}, 16'h0000);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        cnt_base = cyc;
    endtask

    initial begin
        int r;
        int k;
        logic [8:0]  a;
        logic [15:0] d;
        rst_n     = 1'b0;
        addr_mem  = 9'h000;
        wdata_mem = 16'h0000;
        write_mem = 1'b0;
        sw_in     = 16'h0000;
        model_reset();
        #12;
        check_eq("reset rdata", rdata_mem, 16'h0000);
        check_eq("reset led", led_out, 16'h0000);
        check_eq("reset flag", {15'b0, timer_flag}, 16'h0000);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        cnt_base = cyc;
        rd(9'h1FF);

        // Give every RAM word a known value.
        for (int i = 0; i < 256; i++) wr(9'(i), 16'($urandom));

        // RAM round trip and top word.
        wr(9'h012, 16'hBEEF);
        rd(9'h012);
        check_eq("ram 012", last_rd, 16'hBEEF);
        wr(9'h0FF, 16'h1234);
        rd(9'h0FF);
        check_eq("ram 0FF", last_rd, 16'h1234);

        // Read-first on a same-address write.
        wr(9'h020, 16'h5555);
        wr(9'h020, 16'hAAAA);
        check_eq("read-first old", last_rd, 16'h5555);
        rd(9'h020);
        check_eq("read-first new", last_rd, 16'hAAAA);

        // MMIO and unmapped addresses.
        wr(9'h100, 16'h00F0);
        check_eq("led write", led_out, 16'h00F0);
        wr(9'h140, 16'hFFFF);
        sw_in = 16'h0A0A;
        rd(9'h1FF);
        rd(9'h1FF);
        rd(9'h140);
        check_eq("switch sync", last_rd, 16'h0A0A);
        rd(9'h1FF);
        check_eq("unmapped read", last_rd, 16'h0000);
        wr(9'h1FF, 16'hDEAD);
        rd(9'h000);

        // Counter clear then two reads.
        wr(9'h180, 16'h1111);
        rd(9'h180);
        check_eq("cnt after clear", last_rd, 16'h0000);
        rd(9'h180);
        check_eq("cnt +1", last_rd, 16'h0001);

        // Timer flag: compare=5 right after a clear.
        wr(9'h180, 16'h0000);
        wr(9'h1C0, 16'h0005);
        repeat (4) rd(9'h1FF);
        check_eq("flag before match", {15'b0, timer_flag}, 16'h0000);
        rd(9'h1FF);
        check_eq("flag after match", {15'b0, timer_flag}, 16'h0001);
        rd(9'h1C1);
        check_eq("status read", last_rd, 16'h0001);
        wr(9'h1C1, 16'h0000);
        check_eq("flag cleared", {15'b0, timer_flag}, 16'h0000);
        wr(9'h180, 16'h0000);
        repeat (5) rd(9'h1FF);
        wr(9'h1C1, 16'h0000);
        check_eq("clear vs match", {15'b0, timer_flag}, 16'h0001);

        // Async reset with LED and flag set; RAM survives.
        reset_mid();
        rd(9'h012);
        check_eq("ram after reset", last_rd, 16'hBEEF);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 9);
            d = 16'($urandom);
            case (r)
                0, 1, 2, 3: a = 9'($urandom_range(0, 255));
                4: a = 9'h100;
                5: a = 9'h140;
                6: a = 9'h180;
                7: begin
                    a = 9'h1C0;
                    d = 16'(m_cnt() + 16'($urandom_range(1, 30)));
                end
                8: a = 9'h1C1;
                default: a = 9'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) sw_in = 16'($urandom);
            if (a == 9'h180 && $urandom_range(0, 3) != 0) access(a, d, 1'b0);
            else access(a, d, 1'($urandom_range(0, 1)));
        end

        // Full counter wrap with compare=0: the flag must never set.
        wr(9'h1C0, 16'h0000);
        wr(9'h1C1, 16'h0000);
        wr(9'h180, 16'h0000);
        k = 0;
        while (m_cnt() != 16'hFFFF && k < 70000) begin
            rd(9'h1C1);
            k++;
        end
        rd(9'h180);
        check_eq("cnt at FFFF", last_rd, 16'hFFFF);
        rd(9'h180);
        check_eq("cnt wrap", last_rd, 16'h0000);
        check_eq("no flag on wrap", {15'b0, timer_flag}, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the pipeline's stage-3/stage-4 data interface. It accepts the address, write-data and write-strobe that the memory-write stage drives, and returns registered read data in the following cycle, where the register-write stage consumes it. It decodes the 9-bit word address into three regions: a 256-word data RAM, a small memory-mapped I/O region, and everything else, which reads as zero.

## Interface
- RAM_WORDS, 256: data RAM depth in 16-bit words, occupying addresses 0x000–0x0FF.
- SYNC_STAGES, 2: synchronizer depth for sw_in.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- addr_mem  in  9  word address from the memory-write stage.
- wdata_mem  in  16  store data.
- write_mem  in  1  store strobe; the store commits at the rising edge that ends the cycle.
- rdata_mem  out  16  registered read data for the register-write stage.
- sw_in  in  16  asynchronous switch inputs.
- led_out  out  16  LED register value.
- timer_flag  out  1  sticky compare-match flag.

## Operation
- Address map (the full 9-bit address is decoded):
  - 0x000–0x0FF: RAM, read/write. RAM contents are not reset.
  - 0x100: LED register, read/write.
  - 0x140: synchronized switches, read-only; writes are ignored.
  - 0x180: cycle counter, 16 bits. A read returns the current count. A write of any value clears the counter.
  - 0x1C0: compare register, read/write.
  - 0x1C1: status register. A read returns {15'b0, timer_flag}. A write of any value clears the flag.
  - Any other address reads 0x0000; writes to it are ignored.
- Cycle counter: increments by 1 every cycle and wraps from 0xFFFF to 0x0000.
- Timer flag:
  - Sets when the counter equals the compare register and the compare register is nonzero.
  - Stays set until cleared through 0x1C1.
- Switch synchronizer: sw_in passes through SYNC_STAGES flops. A 0x140 read returns the last stage.
- Read mux:
  - A read is performed every cycle whether or not write_mem is asserted. Writes therefore also produce read data.
  - The selected source is registered into rdata_mem.
- Reset values: rdata_mem=0, led_out=0, timer_flag=0, counter=0, compare=0, synchronizer flops=0.

## Timing
- Cycle N: addr_mem, wdata_mem and write_mem are stable.
  - At the edge ending N, the store commits and rdata_mem captures the read of addr_mem.
  - rdata_mem is valid for the whole of cycle N+1. Read latency is 1 cycle.
- Read-during-write, same address: read-first.
  - rdata_mem in N+1 carries the value before the write.
  - The new value is visible to a read in N+1 (data returned in N+2).
- Register reads sample pre-edge values.
  - A counter read in cycle N returns the count during N. If N is the cycle after the counter's last clear, that value is 0.
  - The LED, compare and status registers all return their pre-write value on the write cycle.
- Simultaneous events:
  - Counter clear and increment in the same cycle: clear wins. The counter is 0 in N+1 and 1 in N+2.
  - Flag set and flag clear in the same cycle: set wins, so no match is lost.
  - Compare written in the same cycle as a match on the old compare value: the old value is used for that cycle.
- Synchronizer latency: a change on sw_in is readable after SYNC_STAGES edges.
- led_out and timer_flag are registered outputs; each changes the cycle after its cause.
- rst_n assertion: all registers go to their reset values immediately, without waiting for a clock edge.
  - A store in flight at reset is dropped only if it targets a register. RAM is not reset, and a RAM write in the edge coincident with deassertion is not guaranteed.
  - The first legal access is in the first full cycle after deassertion.

## Test plan
- RAM round trip: write 0xBEEF to 0x012, then read 0x012 -> rdata_mem=0xBEEF one cycle after the read cycle. Read 0x0FF after writing 0x1234 there -> 0x1234.
- Read-first: write 0x5555 to 0x020, then write 0xAAAA to 0x020 -> rdata_mem=0x5555 after the second write. A following read of 0x020 -> 0xAAAA.
- MMIO and unmapped addresses:
  - Write 0x00F0 to 0x100 -> led_out=0x00F0 the next cycle.
  - Write to 0x140 -> no effect.
  - Drive sw_in=0x0A0A, wait 2 cycles, read 0x140 -> 0x0A0A.
  - Read 0x1FF -> 0x0000. Write to 0x1FF, then read 0x0000 -> RAM[0] unchanged.
- Counter:
  - Write to 0x180 in cycle N, then read in N+1 -> 0x0000; read again in N+2 -> 0x0001.
  - Force the counter to 0xFFFF (read it back to confirm) -> the next cycle reads 0x0000.
- Timer flag:
  - Compare=0x0005 written right after a counter clear -> timer_flag rises the cycle after the count equals 5.
  - Read 0x1C1 -> 0x0001.
  - Write 0x1C1 on a non-matching cycle -> the flag drops.
  - Clear coincident with a match -> the flag stays 1.
  - Compare=0 -> the flag never sets across a full counter wrap.
- Async reset: assert rst_n low mid-cycle with led_out=0x00F0 and timer_flag=1 -> led_out, rdata_mem and timer_flag go to 0 before the next edge. After release, RAM data written before reset still reads back.
